// File: rtl/adder_chk_pkg.sv
// Shared types and helpers for the adder stimulus/checker block.
package adder_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned DEFAULT_WIDTH  = 4;
  localparam int unsigned DEFAULT_SETTLE = 2;

  // Number of operand pairs in one exhaustive sweep.
  function automatic int unsigned num_vec(input int unsigned width);
    return 32'd1 << (2 * width);
  endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Golden combinational adder: {carry, sum} = a + b.
module adder_ref_model #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o
);

  assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/adder_stim_checker.sv
// Exhaustive stimulus driver and result checker for an external WIDTH-bit adder.
// Optional build macro: ADDER_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module adder_stim_checker
  import adder_chk_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned SETTLE = DEFAULT_SETTLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*WIDTH:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int unsigned IW = 2 * WIDTH;
  localparam int unsigned EW = 2 * WIDTH + 1;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(num_vec(WIDTH) - 1);
  localparam logic [EW-1:0] ERR_MAX     = {EW{1'b1}};

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    settle_q, settle_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [EW-1:0]    err_q, err_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;

  logic [WIDTH:0]   golden;
  logic             mismatch;
  logic             last_vec;
  logic             start_ok;

  adder_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (golden)
  );

  assign mismatch = (state_q == ST_CHECK) && ({cout, d} != golden);
  assign last_vec = (idx_q == LAST_IDX);
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of process ordering.
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_DRIVE;
      ST_DRIVE: state_d = ST_WAIT;
      ST_WAIT:  if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
      ST_CHECK: begin
`ifdef ADDER_CHK_STOP_ON_FAIL_EN
        if (mismatch || last_vec) state_d = ST_DONE;
`else
        if (last_vec) state_d = ST_DONE;
`endif
        else state_d = ST_DRIVE;
      end
      ST_DONE:  if (start) state_d = ST_DRIVE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      ST_DRIVE, ST_WAIT, ST_CHECK: busy = 1'b1;
      ST_DONE:                     done = 1'b1;
      default: ;
    endcase
    pass = done && (err_q == '0);
  end

  // Datapath next-state: vector index, settle counter, operands, error record.
  always_comb begin
    idx_d    = idx_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;

    if (start_ok) begin
      idx_d    = '0;
      settle_d = '0;
      err_d    = '0;
      fail_a_d = '0;
      fail_b_d = '0;
    end

    unique case (state_q)
      ST_DRIVE: begin
        a_d      = idx_q[IW-1:WIDTH];
        b_d      = idx_q[WIDTH-1:0];
        settle_d = '0;
      end
      ST_WAIT:  settle_d = settle_q + 1'b1;
      ST_CHECK: begin
        // Wraps to zero after the last vector; the FSM is already heading to DONE.
        idx_d = idx_q + 1'b1;
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (err_q == '0) begin
            fail_a_d = a_q;
            fail_b_d = b_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      settle_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
    end else begin
      idx_q    <= idx_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;

endmodule

// File: tb/tb_adder_stim_checker.sv
// Bench for adder_stim_checker: an external adder with selectable faults closes the loop.
module tb_adder_stim_checker;

`ifdef ADDER_CHK_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  localparam int VEC_CYC = 4;
  localparam int FULL    = 256 * VEC_CYC;
  localparam int BUDGET  = 1200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a, b, d;
  logic       cout;
  logic       busy, done, pass;
  logic [8:0] err_count;
  logic [3:0] fail_a, fail_b;

  int         fault_mode;
  logic [4:0] corrupt [256];
  logic [4:0] cmask;
  logic [4:0] adder_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_stim_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .d         (d),
    .cout      (cout),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_a    (fail_a),
    .fail_b    (fail_b)
  );

  // Board adder with planted faults: 1 cout stuck 0, 2 d[0] stuck 0,
  // 3 d[3] inverted, 4 random per-vector corruption.
  function automatic logic [4:0] env_adder(input logic [3:0] x, input logic [3:0] y,
                                            input int mode, input logic [4:0] mask);
    logic [4:0] r;
    r = {1'b0, x} + {1'b0, y};
    case (mode)
      1: r[4] = 1'b0;
      2: r[0] = 1'b0;
      3: r[3] = ~r[3];
      4: r = r ^ mask;
      default: ;
    endcase
    return r;
  endfunction

  assign cmask = corrupt[{a, b}];
  always_comb adder_out = env_adder(a, b, fault_mode, cmask);
  assign {cout, d} = adder_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: walk all pairs in sweep order, count wrong results, note the first.
  task automatic model(output int err, output int fa, output int fb, output int cyc);
    err = 0; fa = 0; fb = 0; cyc = 0;
    for (int i = 0; i < 256; i++) begin
      int x, y;
      logic [4:0] obs;
      x   = i / 16;
      y   = i % 16;
      obs = env_adder(4'(x), 4'(y), fault_mode, corrupt[i]);
      cyc += VEC_CYC;
      if (int'(obs) != x + y) begin
        if (err == 0) begin
          fa = x;
          fb = y;
        end
        err++;
        if (STOP_EN) break;
      end
    end
  endtask

  task automatic run_sweep(input string tag, input int exp_err, input int exp_fa,
                           input int exp_fb, input int exp_cyc, input bit hold);
    int n;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    check({tag, " done_cleared"}, 32'(done), 32'd0);
    n = 0;
    while (!done && n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
      if (hold && n == 500) start = 1'b0;
    end
    start = 1'b0;
    check({tag, " cycles_to_done"}, 32'(n), 32'(exp_cyc));
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_low"}, 32'(busy), 32'd0);
    check({tag, " err_count"}, 32'(err_count), 32'(exp_err));
    check({tag, " pass"}, 32'(pass), 32'(exp_err == 0));
    check({tag, " fail_a"}, 32'(fail_a), 32'(exp_fa));
    check({tag, " fail_b"}, 32'(fail_b), 32'(exp_fb));
    check({tag, " last_ab"}, 32'({a, b}), 32'(exp_cyc / VEC_CYC - 1));
    repeat (5) @(posedge clk);
    #1;
    check({tag, " done_held"}, 32'({done, err_count}), 32'({1'b1, 9'(exp_err)}));
  endtask

  typedef struct {
    string name;
    int    mode;
    int    err;
    int    fa;
    int    fb;
    int    cyc;
    bit    hold;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int e, fa, fb, cyc;

    tbl[0] = '{"good",       0, 0,                   0, 0,  FULL,                 1'b0};
    tbl[1] = '{"cout_stuck", 1, STOP_EN ? 1 : 120,   1, 15, STOP_EN ? 128 : FULL, 1'b0};
    tbl[2] = '{"good_hold",  0, 0,                   0, 0,  FULL,                 1'b1};
    tbl[3] = '{"d0_stuck",   2, STOP_EN ? 1 : 128,   0, 1,  STOP_EN ? 8 : FULL,   1'b0};
    tbl[4] = '{"d3_flip",    3, STOP_EN ? 1 : 256,   0, 0,  STOP_EN ? 4 : FULL,   1'b0};
    tbl[5] = '{"rerun_good", 0, 0,                   0, 0,  FULL,                 1'b0};

    for (int i = 0; i < 256; i++) corrupt[i] = '0;
    fault_mode = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    #12;
    check("reset_outputs", 32'({a, b, busy, done, pass, err_count, fail_a, fail_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("idle_start_accepted", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_abort_early", 32'({busy, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      fault_mode = tbl[k].mode;
      run_sweep(tbl[k].name, tbl[k].err, tbl[k].fa, tbl[k].fb, tbl[k].cyc, tbl[k].hold);
    end

    // Reset mid-sweep: everything clears at once, then a clean sweep follows.
    fault_mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midsweep_reset_outputs",
          32'({a, b, busy, done, pass, err_count, fail_a, fail_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", 32'({busy, done}), 32'd0);
    fault_mode = 0;
    run_sweep("after_reset", 0, 0, 0, FULL, 1'b0);

    // Randomised corruption checked against the reference walk.
    fault_mode = 4;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++)
        corrupt[i] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      model(e, fa, fb, cyc);
      run_sweep($sformatf("random%0d", r), e, fa, fb, cyc, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
